dcache_write_buffer: RTL and testbench

//  Parametrised data-cache write path: byte/word-merges a CPU store of 1..BYTES bytes into the hit cache line
//  and queues the matching write-through to memory. The memory write is 1 or 2 DATA_W beats with per-beat byteenables.

---
 rtl/dcache_write_buffer_pkg.sv | 16 +
 rtl/dcache_write_buffer_if.sv | 51 +++++
 rtl/dcache_write_align.sv | 42 ++++
 rtl/dcache_write_buffer.sv | 199 +++++++++++++++++++
 tb/tb_dcache_write_buffer.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dcache_write_buffer_pkg.sv
// Shared definitions for the dcache write buffer slice.
// Contents:
//   drain_state_t  - drain FSM state encoding (IDLE, BEAT0, BEAT1)
//   BURST_ONE/TWO  - Avalon burstcount values for single- and double-beat writes
package dcache_write_buffer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2
    } drain_state_t;

    localparam logic [1:0] BURST_ONE = 2'd1;
    localparam logic [1:0] BURST_TWO = 2'd2;

endpackage

// File: rtl/dcache_write_buffer_if.sv
// Bus bundle between the dcache store pipeline, the write buffer and the
// Avalon-style memory write port.
// Signals:
//   req_*            store request from the CPU side (valid/ready handshake)
//   line_in          current contents of the hit cache line
//   line_merged(_v)  merged line returned to the cache, with a 1-cycle strobe
//   mem_*            Avalon write master (address, write, burstcount,
//                    byteenable, writedata, waitrequest)
//   empty, count     queue status
// Modports:
//   master - the write buffer's view
//   slave  - the surrounding environment's view
interface dcache_write_buffer_if #(
    parameter int DATA_W = 32,
    parameter int LINE_W = 128,
    parameter int DEPTH  = 4
);
    localparam int BYTES = DATA_W / 8;
    localparam int LEN_W = $clog2(BYTES) + 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              req_valid;
    logic              req_ready;
    logic [31:0]       req_address;
    logic [LEN_W-1:0]  req_length;
    logic [DATA_W-1:0] req_data;
    logic [LINE_W-1:0] line_in;
    logic [LINE_W-1:0] line_merged;
    logic              line_merged_valid;
    logic [31:0]       mem_address;
    logic              mem_write;
    logic [1:0]        mem_burstcount;
    logic [BYTES-1:0]  mem_byteenable;
    logic [DATA_W-1:0] mem_writedata;
    logic              mem_waitrequest;
    logic              empty;
    logic [CNT_W-1:0]  count;

    modport master (
        input  req_valid, req_address, req_length, req_data, line_in, mem_waitrequest,
        output req_ready, line_merged, line_merged_valid, mem_address, mem_write,
               mem_burstcount, mem_byteenable, mem_writedata, empty, count
    );

    modport slave (
        output req_valid, req_address, req_length, req_data, line_in, mem_waitrequest,
        input  req_ready, line_merged, line_merged_valid, mem_address, mem_write,
               mem_burstcount, mem_byteenable, mem_writedata, empty, count
    );

endinterface

// File: rtl/dcache_write_align.sv
// Combinational store aligner.
// Places LSB-aligned store data at its byte position inside a two-word window
// and derives the per-beat byteenables and the resulting burst length.
// Ports:
//   addr_low  in   byte offset within a memory word
//   length    in   number of bytes stored (1..BYTES)
//   data      in   LSB-aligned store data
//   shifted   out  data shifted into the two-word window
//   be0/be1   out  byteenables of the first/second beat
//   beats     out  burstcount: BURST_TWO when the store crosses a word boundary
module dcache_write_align
    import dcache_write_buffer_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [$clog2(DATA_W/8)-1:0] addr_low,
    input  logic [$clog2(DATA_W/8):0]   length,
    input  logic [DATA_W-1:0]           data,
    output logic [2*DATA_W-1:0]         shifted,
    output logic [DATA_W/8-1:0]         be0,
    output logic [DATA_W/8-1:0]         be1,
    output logic [1:0]                  beats
);
    localparam int BYTES = DATA_W / 8;

    logic [2*BYTES-1:0] len_mask;
    logic [2*BYTES-1:0] mask;

    // Build a run of 'length' ones, then slide it and the data to the store offset.
    always_comb begin
        len_mask = '0;
        for (int j = 0; j < BYTES; j++) begin
            len_mask[j] = (j < int'(length));
        end
        mask    = len_mask << addr_low;
        shifted = {{DATA_W{1'b0}}, data} << {addr_low, 3'b000};
        be0     = mask[BYTES-1:0];
        be1     = mask[2*BYTES-1:BYTES];
        beats   = (be1 != '0) ? BURST_TWO : BURST_ONE;
    end

endmodule

// File: rtl/dcache_write_buffer.sv
// Data-cache write path: merges a CPU store into the hit cache line and queues
// the matching write-through to memory as a 1- or 2-beat Avalon burst.
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   bus       dcache_write_buffer_if.master (store request, merged line,
//             memory write master, queue status)
module dcache_write_buffer
    import dcache_write_buffer_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LINE_W = 128,
    parameter int DEPTH  = 4
) (
    input logic                   clk,
    input logic                   rst,
    dcache_write_buffer_if.master bus
);
    localparam int BYTES      = DATA_W / 8;
    localparam int ALIGN_W    = $clog2(BYTES);
    localparam int LEN_W      = ALIGN_W + 1;
    localparam int LINE_BYTES = LINE_W / 8;
    localparam int OFF_W      = $clog2(LINE_BYTES);
    localparam int PTR_W      = $clog2(DEPTH);
    localparam int CNT_W      = PTR_W + 1;
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(BYTES);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [31:0]         q_addr  [DEPTH];
    logic [1:0]          q_beats [DEPTH];
    logic [BYTES-1:0]    q_be0   [DEPTH];
    logic [BYTES-1:0]    q_be1   [DEPTH];
    logic [2*DATA_W-1:0] q_data  [DEPTH];

    logic [PTR_W-1:0]    head, tail, load_idx;
    logic [CNT_W-1:0]    count, count_next;
    logic                req_ready_q;
    drain_state_t        state, state_next;
    logic [31:0]         cur_addr;
    logic [1:0]          cur_beats;
    logic [BYTES-1:0]    cur_be0, cur_be1;
    logic [2*DATA_W-1:0] cur_data;
    logic [LINE_W-1:0]   merged_next, line_merged_q;
    logic                line_merged_valid_q;
    logic                accept, len_ok, push, pop, load;
    logic [OFF_W-1:0]    line_off;
    logic [2*DATA_W-1:0] al_shifted;
    logic [BYTES-1:0]    al_be0, al_be1;
    logic [1:0]          al_beats;

    // Illegal lengths still complete the handshake but never reach the queue.
    assign accept   = bus.req_valid & req_ready_q;
    assign len_ok   = (bus.req_length != '0) && (bus.req_length <= LEN_MAX);
    assign push     = accept & len_ok;
    assign line_off = bus.req_address[OFF_W-1:0];

    dcache_write_align #(.DATA_W(DATA_W)) u_align (
        .addr_low (bus.req_address[ALIGN_W-1:0]),
        .length   (bus.req_length),
        .data     (bus.req_data),
        .shifted  (al_shifted),
        .be0      (al_be0),
        .be1      (al_be1),
        .beats    (al_beats)
    );

    // Overlay store bytes on the line; bytes running past the line end are dropped.
    always_comb begin
        merged_next = bus.line_in;
        for (int j = 0; j < BYTES; j++) begin
            if ((j < int'(bus.req_length)) && ((int'(line_off) + j) < LINE_BYTES)) begin
                merged_next[8*(int'(line_off)+j) +: 8] = bus.req_data[8*j +: 8];
            end
        end
    end

    // Queue storage needs no reset: only entries below 'count' are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[tail]  <= {bus.req_address[31:ALIGN_W], {ALIGN_W{1'b0}}};
            q_beats[tail] <= al_beats;
            q_be0[tail]   <= al_be0;
            q_be1[tail]   <= al_be1;
            q_data[tail]  <= al_shifted;
        end
    end

    // The head entry stays counted until its last beat is accepted, so a
    // finishing burst can chain to head+1 without an idle cycle in between.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        load       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (count != '0) begin
                    load       = 1'b1;
                    state_next = ST_BEAT0;
                end
            end
            ST_BEAT0: begin
                if (!bus.mem_waitrequest) begin
                    if (cur_beats == BURST_TWO) begin
                        state_next = ST_BEAT1;
                    end else begin
                        pop        = 1'b1;
                        load       = (count > CNT_ONE);
                        state_next = (count > CNT_ONE) ? ST_BEAT0 : ST_IDLE;
                    end
                end
            end
            ST_BEAT1: begin
                if (!bus.mem_waitrequest) begin
                    pop        = 1'b1;
                    load       = (count > CNT_ONE);
                    state_next = (count > CNT_ONE) ? ST_BEAT0 : ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign load_idx = pop ? (head + PTR_ONE) : head;

    always_comb begin
        case ({push, pop})
            2'b10:   count_next = count + CNT_ONE;
            2'b01:   count_next = count - CNT_ONE;
            default: count_next = count;
        endcase
    end

    // Queue control, FSM state and the burst held on the memory port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            req_ready_q <= 1'b1;
            cur_addr    <= '0;
            cur_beats   <= BURST_ONE;
            cur_be0     <= '0;
            cur_be1     <= '0;
            cur_data    <= '0;
        end else begin
            state       <= state_next;
            count       <= count_next;
            req_ready_q <= (count_next != CNT_FULL);
            if (push) tail <= tail + PTR_ONE;
            if (pop)  head <= head + PTR_ONE;
            if (load) begin
                cur_addr  <= q_addr[load_idx];
                cur_beats <= q_beats[load_idx];
                cur_be0   <= q_be0[load_idx];
                cur_be1   <= q_be1[load_idx];
                cur_data  <= q_data[load_idx];
            end
        end
    end

    // Merged line register; it holds its value between legal stores.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_merged_q       <= '0;
            line_merged_valid_q <= 1'b0;
        end else begin
            line_merged_valid_q <= push;
            if (push) line_merged_q <= merged_next;
        end
    end

    always_comb begin
        bus.mem_byteenable = '0;
        bus.mem_writedata  = '0;
        case (state)
            ST_BEAT0: begin
                bus.mem_byteenable = cur_be0;
                bus.mem_writedata  = cur_data[DATA_W-1:0];
            end
            ST_BEAT1: begin
                bus.mem_byteenable = cur_be1;
                bus.mem_writedata  = cur_data[2*DATA_W-1:DATA_W];
            end
            default: ;
        endcase
    end

    assign bus.req_ready         = req_ready_q;
    assign bus.line_merged       = line_merged_q;
    assign bus.line_merged_valid = line_merged_valid_q;
    assign bus.mem_write         = (state != ST_IDLE);
    assign bus.mem_address       = cur_addr;
    assign bus.mem_burstcount    = cur_beats;
    assign bus.empty             = (count == '0) && (state == ST_IDLE);
    assign bus.count             = count;

endmodule

// File: tb/tb_dcache_write_buffer.sv
// Self-checking bench for dcache_write_buffer (DATA_W=32, LINE_W=128, DEPTH=4).
// Directed stores push their expected merged line and memory beats into
// scoreboard queues; a monitor pops and compares whenever the DUT presents a
// merged line or an accepted memory beat.
module tb_dcache_write_buffer;
    localparam int DATA_W = 32;
    localparam int LINE_W = 128;
    localparam int DEPTH  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    dcache_write_buffer_if #(.DATA_W(DATA_W), .LINE_W(LINE_W), .DEPTH(DEPTH)) bus ();

    dcache_write_buffer #(.DATA_W(DATA_W), .LINE_W(LINE_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  bc;
        logic [3:0]  be;
        logic [31:0] data;
    } beat_t;

    logic [127:0] exp_line_q[$];
    beat_t        exp_beat_q[$];
    int           n_checks = 0;
    int           n_pass   = 0;

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: got %h, wanted %h", name, actual, expected);
    endtask

    task automatic recordUnexpected(input string name, input logic [127:0] actual);
        n_checks++;
        $display("[TB] FAIL %s: got %h, wanted no output", name, actual);
    endtask

    task automatic expectBeat(input logic [31:0] addr, input logic [1:0] bc, input logic [3:0] be, input logic [31:0] data);
        beat_t b;
        b.addr = addr; b.bc = bc; b.be = be; b.data = data;
        exp_beat_q.push_back(b);
    endtask

    task automatic driveReq(input logic [31:0] addr, input logic [2:0] len, input logic [31:0] data,
                            input logic [127:0] line, input bit has_line, input logic [127:0] exp_line);
        @(posedge clk); #1;
        bus.req_valid   = 1'b1;
        bus.req_address = addr;
        bus.req_length  = len;
        bus.req_data    = data;
        bus.line_in     = line;
        if (has_line) exp_line_q.push_back(exp_line);
    endtask

    task automatic waitAccept();
        bit done = 1'b0;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            done = bus.req_ready;
            @(posedge clk); #1;
        end
        bus.req_valid = 1'b0;
        checkOutput("accept_in_time", 128'(done), 128'(1));
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input logic [2:0] len, input logic [31:0] data,
                                 input logic [127:0] line, input bit has_line, input logic [127:0] exp_line);
        driveReq(addr, len, data, line, has_line, exp_line);
        waitAccept();
    endtask

    task automatic waitEmpty(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            done = bus.empty && (exp_beat_q.size() == 0);
        end
        checkOutput(name, 128'(done), 128'(1));
    endtask

    // Scoreboard monitor: compares every merged line and every accepted beat.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.line_merged_valid) begin
                    if (exp_line_q.size() > 0) checkOutput("line_merged", bus.line_merged, exp_line_q.pop_front());
                    else recordUnexpected("unexpected_line_merged", bus.line_merged);
                end
                if (bus.mem_write && !bus.mem_waitrequest) begin
                    if (exp_beat_q.size() > 0) begin
                        beat_t e;
                        e = exp_beat_q.pop_front();
                        checkOutput("beat_address",    128'(bus.mem_address),    128'(e.addr));
                        checkOutput("beat_burstcount", 128'(bus.mem_burstcount), 128'(e.bc));
                        checkOutput("beat_byteenable", 128'(bus.mem_byteenable), 128'(e.be));
                        checkOutput("beat_writedata",  128'(bus.mem_writedata),  128'(e.data));
                    end else begin
                        recordUnexpected("unexpected_beat", 128'({bus.mem_address, bus.mem_byteenable, bus.mem_writedata}));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.req_valid       = 1'b0;
        bus.req_address     = '0;
        bus.req_length      = '0;
        bus.req_data        = '0;
        bus.line_in         = '0;
        bus.mem_waitrequest = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rst_req_ready",   128'(bus.req_ready), 128'(1));
        checkOutput("rst_line_merged", bus.line_merged, 128'(0));
        checkOutput("rst_line_valid",  128'(bus.line_merged_valid), 128'(0));
        checkOutput("rst_mem_write",   128'(bus.mem_write), 128'(0));
        checkOutput("rst_mem_address", 128'(bus.mem_address), 128'(0));
        checkOutput("rst_burstcount",  128'(bus.mem_burstcount), 128'(1));
        checkOutput("rst_byteenable",  128'(bus.mem_byteenable), 128'(0));
        checkOutput("rst_writedata",   128'(bus.mem_writedata), 128'(0));
        checkOutput("rst_empty",       128'(bus.empty), 128'(1));
        checkOutput("rst_count",       128'(bus.count), 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: unaligned 2-byte store crossing a word boundary
        expectBeat(32'h100, 2'd2, 4'b1000, 32'hEF000000);
        expectBeat(32'h100, 2'd2, 4'b0001, 32'h000000BE);
        applyStimulus(32'h103, 3'd2, 32'h0000BEEF, 128'h0, 1'b1, 128'h000000BE_EF000000);
        waitEmpty("t1_drain");

        // 2: full word held by waitrequest for three cycles
        bus.mem_waitrequest = 1'b1;
        expectBeat(32'h20, 2'd1, 4'b1111, 32'h11223344);
        applyStimulus(32'h20, 3'd4, 32'h11223344, 128'hFFEEDDCC_BBAA9988_77665544_33221100,
                      1'b1, 128'hFFEEDDCC_BBAA9988_77665544_11223344);
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("t2_hold_write", 128'(bus.mem_write), 128'(1));
            checkOutput("t2_hold_addr",  128'(bus.mem_address), 128'(32'h20));
            checkOutput("t2_hold_be",    128'(bus.mem_byteenable), 128'(4'b1111));
            checkOutput("t2_hold_data",  128'(bus.mem_writedata), 128'(32'h11223344));
            @(posedge clk); #1;
        end
        bus.mem_waitrequest = 1'b0;
        @(negedge clk);
        checkOutput("t2_not_empty_in_beat", 128'(bus.empty), 128'(0));
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("t2_empty_after_accept", 128'(bus.empty), 128'(1));

        // 3: fill the queue while memory stalls, fifth store must wait
        bus.mem_waitrequest = 1'b1;
        for (int n = 1; n <= 5; n++) expectBeat(32'h200 + 32'(4*(n-1)), 2'd1, 4'b1111, 32'hA0000000 + 32'(n));
        applyStimulus(32'h200, 3'd4, 32'hA0000001, 128'h0, 1'b1, 128'h00000000_00000000_00000000_A0000001);
        applyStimulus(32'h204, 3'd4, 32'hA0000002, 128'h0, 1'b1, 128'h00000000_00000000_A0000002_00000000);
        applyStimulus(32'h208, 3'd4, 32'hA0000003, 128'h0, 1'b1, 128'h00000000_A0000003_00000000_00000000);
        applyStimulus(32'h20C, 3'd4, 32'hA0000004, 128'h0, 1'b1, 128'hA0000004_00000000_00000000_00000000);
        @(negedge clk);
        checkOutput("t3_full_ready", 128'(bus.req_ready), 128'(0));
        checkOutput("t3_full_count", 128'(bus.count), 128'(4));
        driveReq(32'h210, 3'd4, 32'hA0000005, 128'h0, 1'b1, 128'h00000000_00000000_00000000_A0000005);
        repeat (2) @(negedge clk);
        checkOutput("t3_fifth_held", 128'(bus.count), 128'(4));
        @(posedge clk); #1;
        bus.mem_waitrequest = 1'b0;
        waitAccept();
        waitEmpty("t3_drain");

        // 4: push and pop on the same edge with two entries queued
        bus.mem_waitrequest = 1'b1;
        expectBeat(32'h300, 2'd1, 4'b1111, 32'hC0000001);
        expectBeat(32'h304, 2'd1, 4'b1111, 32'hC0000002);
        expectBeat(32'h308, 2'd1, 4'b1111, 32'hC0000003);
        applyStimulus(32'h300, 3'd4, 32'hC0000001, 128'h0, 1'b1, 128'h00000000_00000000_00000000_C0000001);
        applyStimulus(32'h304, 3'd4, 32'hC0000002, 128'h0, 1'b1, 128'h00000000_00000000_C0000002_00000000);
        driveReq(32'h308, 3'd4, 32'hC0000003, 128'h0, 1'b1, 128'h00000000_C0000003_00000000_00000000);
        bus.mem_waitrequest = 1'b0;
        waitAccept();
        bus.mem_waitrequest = 1'b1;
        @(negedge clk);
        checkOutput("t4_count_held", 128'(bus.count), 128'(2));
        checkOutput("t4_next_head",  128'(bus.mem_writedata), 128'(32'hC0000002));
        @(posedge clk); #1;
        bus.mem_waitrequest = 1'b0;
        waitEmpty("t4_drain");

        // 5: reset in the middle of the second beat
        bus.mem_waitrequest = 1'b1;
        expectBeat(32'h400, 2'd2, 4'b1000, 32'h5A000000);
        applyStimulus(32'h403, 3'd2, 32'h00005A5A, 128'h0, 1'b1, 128'h0000005A_5A000000);
        @(posedge clk); #1;
        bus.mem_waitrequest = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        bus.mem_waitrequest = 1'b1;
        @(negedge clk);
        checkOutput("t5_in_beat1_be", 128'(bus.mem_byteenable), 128'(4'b0001));
        #2 rst = 1'b1;
        #1;
        checkOutput("t5_rst_write", 128'(bus.mem_write), 128'(0));
        checkOutput("t5_rst_count", 128'(bus.count), 128'(0));
        checkOutput("t5_rst_ready", 128'(bus.req_ready), 128'(1));
        checkOutput("t5_rst_empty", 128'(bus.empty), 128'(1));
        @(posedge clk); #1;
        rst = 1'b0;
        bus.mem_waitrequest = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("t5_no_more_beats", 128'(bus.mem_write), 128'(0));
        end

        // 6: illegal lengths are swallowed; store at the last line byte
        applyStimulus(32'h500, 3'd0, 32'hFFFFFFFF, 128'h0, 1'b0, 128'h0);
        @(negedge clk);
        checkOutput("t6_len0_valid", 128'(bus.line_merged_valid), 128'(0));
        checkOutput("t6_len0_count", 128'(bus.count), 128'(0));
        applyStimulus(32'h504, 3'd5, 32'hFFFFFFFF, 128'h0, 1'b0, 128'h0);
        @(negedge clk);
        checkOutput("t6_len5_valid", 128'(bus.line_merged_valid), 128'(0));
        checkOutput("t6_len5_count", 128'(bus.count), 128'(0));
        checkOutput("t6_line_held",  bus.line_merged, 128'(0));
        expectBeat(32'h10C, 2'd2, 4'b1000, 32'h34000000);
        expectBeat(32'h10C, 2'd2, 4'b0001, 32'h00000012);
        applyStimulus(32'h10F, 3'd2, 32'h00001234, 128'h0, 1'b1, 128'h34000000_00000000_00000000_00000000);
        waitEmpty("t6_drain");

        repeat (3) @(negedge clk);
        checkOutput("line_queue_left", 128'(exp_line_q.size()), 128'(0));
        checkOutput("beat_queue_left", 128'(exp_beat_q.size()), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
